// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, answers the control FSM's
// ir_load handshake with a variable-latency memory read.
module instr_fetch_unit #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 TIMEOUT  = 15,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ir_load,
    input  logic              pc_update,
    input  logic              pc_sel,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              pend_valid;
    logic              pend_sel;
    logic [ADDR_W-1:0] pend_target;

    logic              timeout_hit;
    logic              fetch_end;
    logic              exit_upd;
    logic              exit_sel;
    logic [ADDR_W-1:0] exit_target;

    assign mem_addr = pc;

    assign timeout_hit = (count == CNT_LAST) && !mem_ack;
    assign fetch_end   = (state == REQ) && (mem_ack || timeout_hit);

    // A request arriving on the leaving edge is the newest, so it beats the slot.
    always_comb begin
        exit_upd    = pend_valid;
        exit_sel    = pend_sel;
        exit_target = pend_target;
        if (pc_update) begin
            exit_upd    = 1'b1;
            exit_sel    = pc_sel;
            exit_target = branch_target;
        end
    end

    function automatic logic [ADDR_W-1:0] next_pc(
        input logic              sel,
        input logic [ADDR_W-1:0] target,
        input logic [ADDR_W-1:0] cur
    );
        return sel ? target : cur + ADDR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            count       <= '0;
            mem_rd      <= 1'b0;
            fetch_busy  <= 1'b0;
            fetch_done  <= 1'b0;
            fetch_err   <= 1'b0;
            pend_valid  <= 1'b0;
            pend_sel    <= 1'b0;
            pend_target <= '0;
        end else begin
            fetch_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    pend_valid <= 1'b0;
                    if (pc_update) begin
                        pc <= next_pc(pc_sel, branch_target, pc);
                    end
                    if (ir_load) begin
                        state      <= REQ;
                        mem_rd     <= 1'b1;
                        fetch_busy <= 1'b1;
                        count      <= '0;
                    end
                end
                REQ: begin
                    if (fetch_end) begin
                        instr      <= mem_ack ? mem_rdata : NOP_WORD;
                        fetch_done <= 1'b1;
                        state      <= IDLE;
                        mem_rd     <= 1'b0;
                        fetch_busy <= 1'b0;
                        count      <= '0;
                        pend_valid <= 1'b0;
                        if (!mem_ack) begin
                            fetch_err <= 1'b1;
                        end
                        if (exit_upd) begin
                            pc <= next_pc(exit_sel, exit_target, pc);
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                        // Hold pc steady so mem_addr is stable for the whole read.
                        if (pc_update) begin
                            pend_valid  <= 1'b1;
                            pend_sel    <= pc_sel;
                            pend_target <= branch_target;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a
// transaction-level model of PC, IR and the sticky error flag.
module tb_instr_fetch_unit;

    localparam int          TIMEOUT  = 15;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP_WORD = 16'h0000;

    logic        clk;
    logic        reset;
    logic        ir_load;
    logic        pc_update;
    logic        pc_sel;
    logic [15:0] branch_target;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_err;

    instr_fetch_unit #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ir_load       (ir_load),
        .pc_update     (pc_update),
        .pc_sel        (pc_sel),
        .branch_target (branch_target),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .instr         (instr),
        .pc            (pc),
        .fetch_busy    (fetch_busy),
        .fetch_done    (fetch_done),
        .fetch_err     (fetch_err)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        bit          err;
        logic [15:0] pc;
        int          done_cyc;
    } exp_t;

    typedef struct {
        int          edge_n;
        bit          sel;
        logic [15:0] tgt;
    } upd_t;

    exp_t        exp_q[$];
    upd_t        mid_q[$];
    logic [15:0] mpc;
    bit          merr;
    int          cyc;
    int          checks;
    int          errors;
    bit          started;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: every output event is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t x;
        if (started && !reset) begin
            if (mem_rd) begin
                if (exp_q.size() == 0) fail_now("unexpected_rd");
                else chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
            end
            if (fetch_done) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_done");
                end else begin
                    x = exp_q.pop_front();
                    chk("instr", 32'(instr), 32'(x.instr));
                    chk("fetch_err", 32'(fetch_err), 32'(x.err));
                    chk("pc_after", 32'(pc), 32'(x.pc));
                    chk("done_cycle", 32'(cyc), 32'(x.done_cyc));
                    chk("busy_off", 32'(fetch_busy), 32'd0);
                end
            end else if (exp_q.size() != 0 && cyc >= exp_q[0].done_cyc) begin
                void'(exp_q.pop_front());
                fail_now("missing_done");
            end
        end
    end

    task automatic clear_inputs();
        ir_load   = 1'b0;
        pc_update = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        exp_q.delete();
        mpc  = RESET_PC;
        merr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(negedge clk);
            ir_load   = 1'b0;
            pc_update = 1'b0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
        end
    endtask

    task automatic idle_update(input bit sel, input logic [15:0] tgt);
        @(negedge clk);
        ir_load       = 1'b0;
        mem_ack       = 1'b0;
        pc_update     = 1'b1;
        pc_sel        = sel;
        branch_target = tgt;
        mpc = sel ? tgt : mpc + 16'd1;
        @(negedge clk);
        pc_update = 1'b0;
        chk("idle_pc", 32'(pc), 32'(mpc));
    endtask

    // lat = REQ edge carrying mem_ack (1 = first REQ edge); 0 or > TIMEOUT = no ack.
    task automatic fetch(input int lat, input bit up0, input bit sel0,
                         input logic [15:0] tgt0, input logic [15:0] data,
                         input bit rand_mid);
        bit          ack;
        int          edges;
        exp_t        x;
        bit          pv;
        bit          ps;
        logic [15:0] pt;
        ack   = (lat >= 1 && lat <= TIMEOUT);
        edges = ack ? lat : TIMEOUT;
        if (rand_mid) begin
            mid_q.delete();
            for (int e = 1; e < edges; e++)
                if ($urandom_range(0, 3) == 0)
                    mid_q.push_back('{e, bit'($urandom_range(0, 1)),
                                      16'($urandom)});
        end
        if (up0) mpc = sel0 ? tgt0 : mpc + 16'd1;
        x.addr = mpc;
        pv = 1'b0;
        ps = 1'b0;
        pt = '0;
        foreach (mid_q[i]) begin
            if (mid_q[i].edge_n < edges) begin
                pv = 1'b1;
                ps = mid_q[i].sel;
                pt = mid_q[i].tgt;
            end
        end
        if (pv) mpc = ps ? pt : mpc + 16'd1;
        if (!ack) merr = 1'b1;
        x.instr = ack ? data : NOP_WORD;
        x.err   = merr;
        x.pc    = mpc;

        @(negedge clk);
        ir_load       = 1'b1;
        pc_update     = up0;
        pc_sel        = sel0;
        branch_target = tgt0;
        mem_ack       = 1'b0;
        x.done_cyc    = cyc + 1 + edges;
        exp_q.push_back(x);
        for (int e = 1; e <= edges; e++) begin
            @(negedge clk);
            ir_load       = 1'($urandom_range(0, 1));
            pc_update     = 1'b0;
            pc_sel        = 1'($urandom_range(0, 1));
            branch_target = 16'($urandom);
            foreach (mid_q[i]) begin
                if (mid_q[i].edge_n == e && e < edges) begin
                    pc_update     = 1'b1;
                    pc_sel        = mid_q[i].sel;
                    branch_target = mid_q[i].tgt;
                end
            end
            mem_ack   = ack && (e == lat);
            mem_rdata = mem_ack ? data : 16'($urandom);
        end
        @(negedge clk);
        clear_inputs();
        mid_q.delete();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        started = 1'b0;
        reset   = 1'b1;
        pc_sel  = 1'b0;
        branch_target = '0;
        mem_rdata     = '0;
        clear_inputs();
        mpc  = RESET_PC;
        merr = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'(RESET_PC));
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_done", 32'(fetch_done), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        reset   = 1'b0;
        started = 1'b1;

        fetch(3, 1'b0, 1'b0, 16'h0, 16'hA5C3, 1'b0);
        idle_gap(2);
        fetch(1, 1'b0, 1'b0, 16'h0, 16'h1234, 1'b0);
        idle_update(1'b0, 16'h0);

        idle_update(1'b1, 16'hFFFF);
        idle_update(1'b0, 16'h0);
        fetch(2, 1'b1, 1'b1, 16'h0040, 16'h5A5A, 1'b0);

        idle_update(1'b1, 16'h0010);
        mid_q.push_back('{1, 1'b1, 16'h0100});
        mid_q.push_back('{2, 1'b0, 16'h0000});
        fetch(4, 1'b0, 1'b0, 16'h0, 16'hBEEF, 1'b0);

        fetch(0, 1'b0, 1'b0, 16'h0, 16'hDEAD, 1'b0);
        fetch(2, 1'b0, 1'b0, 16'h0, 16'h7777, 1'b0);
        do_reset();
        fetch(TIMEOUT, 1'b0, 1'b0, 16'h0, 16'hC0DE, 1'b0);

        // Reset mid-wait with a queued branch that must be discarded.
        idle_update(1'b1, 16'h0200);
        @(negedge clk);
        ir_load = 1'b1;
        exp_q.push_back('{mpc, 16'h0, 1'b0, mpc, cyc + 100});
        @(negedge clk);
        ir_load       = 1'b0;
        pc_update     = 1'b1;
        pc_sel        = 1'b1;
        branch_target = 16'h1234;
        @(negedge clk);
        pc_update = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mid_busy", 32'(fetch_busy), 32'd0);
        chk("rst_mid_pc", 32'(pc), 32'(RESET_PC));
        exp_q.delete();
        mpc  = RESET_PC;
        merr = 1'b0;
        @(negedge clk);
        chk("rst_mid_done", 32'(fetch_done), 32'd0);
        reset = 1'b0;
        fetch(2, 1'b0, 1'b0, 16'h0, 16'h4321, 1'b0);

        for (int t = 0; t < 60; t++) begin
            int lat;
            if ($urandom_range(0, 2) == 0)
                idle_update(bit'($urandom_range(0, 1)), 16'($urandom));
            idle_gap($urandom_range(0, 2));
            lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT + 1);
            fetch(lat, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom), 1'b1);
        end

        idle_gap(3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
